// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that shares one physical-memory port between the I-cache and the D-cache.
// Only the grant state is registered; forwarding and response routing are combinational.
module pmem_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_read,
    input  logic         i_write,
    input  logic [15:0]  i_address,
    input  logic [127:0] i_wdata,
    output logic         i_resp,
    output logic [127:0] i_rdata,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic         d_resp,
    output logic [127:0] d_rdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   last_r;        // 0: I-cache served last, 1: D-cache served last
    logic   next_last_s;
    logic   i_req_s;
    logic   d_req_s;

    assign i_req_s = i_read | i_write;
    assign d_req_s = d_read | d_write;

    // Read data goes to both clients; each qualifies it with its own resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Grant state and round-robin history; reset favours the I-cache on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            last_r  <= next_last_s;
        end
    end

    // Next-state logic: a dropped request aborts the grant without touching the history.
    always_comb begin
        next_state_s = state_r;
        next_last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    next_state_s = last_r ? GNT_I : GNT_D;
                end else if (i_req_s) begin
                    next_state_s = GNT_I;
                end else if (d_req_s) begin
                    next_state_s = GNT_D;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT_I: begin
                if (pmem_resp) begin
                    next_state_s = IDLE;
                    next_last_s  = 1'b0;
                end else if (i_req_s) begin
                    next_state_s = GNT_I;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT_D: begin
                if (pmem_resp) begin
                    next_state_s = IDLE;
                    next_last_s  = 1'b1;
                end else if (d_req_s) begin
                    next_state_s = GNT_D;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_last_s  = last_r;
            end
        endcase
    end

    // Forward the granted client's transfer; a write strobe overrides a simultaneous read.
    always_comb begin
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state_r)
            GNT_I: begin
                pmem_address = i_address;
                pmem_wdata   = i_wdata;
                pmem_write   = i_write;
                pmem_read    = i_read & ~i_write;
                i_resp       = pmem_resp;
            end
            GNT_D: begin
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                d_resp       = pmem_resp;
            end
            IDLE: begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            default: begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a per-cycle vector table plus hand-written
// sequences for round-robin alternation, long write latency and reset abort.
module tb_pmem_arbiter;

    logic         clk;
    logic         reset;
    logic         i_read, i_write, d_read, d_write;
    logic [15:0]  i_address, d_address;
    logic [127:0] i_wdata, d_wdata;
    logic         i_resp, d_resp;
    logic [127:0] i_rdata, d_rdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] RD = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] IW = 128'h1111_AAAA_1111_AAAA_1111_AAAA_1111_AAAA;
    localparam logic [127:0] DW = 128'h2222_BBBB_2222_BBBB_2222_BBBB_2222_BBBB;

    pmem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic        pr;
        logic        er;
        logic        ew;
        logic [1:0]  src;   // 0: no forwarding check, 1: I-cache, 2: D-cache
        logic        eir;
        logic        edr;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t v(input logic rst, input logic ir, input logic [15:0] ia,
                               input logic dr, input logic dw, input logic [15:0] da,
                               input logic pr, input logic er, input logic ew,
                               input logic [1:0] src, input logic eir, input logic edr);
        vec_t r;
        r.rst = rst; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.pr = pr;
        r.er = er; r.ew = ew; r.src = src; r.eir = eir; r.edr = edr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic edge_in();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        reset = 1'b1; i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = 16'h0000; d_address = 16'h0000; i_wdata = IW; d_wdata = DW;
        pmem_resp = 1'b0; pmem_rdata = RD;

        // Per-cycle table: row inputs and the outputs expected in that same cycle.
        vecs[0]  = v(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[1]  = v(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[2]  = v(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        vecs[3]  = v(1'b0, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        vecs[4]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[5]  = v(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[6]  = v(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[7]  = v(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        vecs[8]  = v(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        vecs[9]  = v(1'b0, 1'b0, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[10] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        vecs[11] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        vecs[12] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[13] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[14] = v(1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[15] = v(1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        vecs[16] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[17] = v(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[18] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[19] = v(1'b0, 1'b1, 16'h4100, 1'b1, 1'b0, 16'h5000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[20] = v(1'b0, 1'b1, 16'h4100, 1'b1, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        vecs[21] = v(1'b0, 1'b1, 16'h4100, 1'b1, 1'b1, 16'h5000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        vecs[22] = v(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        for (int k = 0; k < 23; k++) begin
            edge_in();
            reset = vecs[k].rst; i_read = vecs[k].ir; i_address = vecs[k].ia;
            d_read = vecs[k].dr; d_write = vecs[k].dw; d_address = vecs[k].da;
            pmem_resp = vecs[k].pr;
            settle();
            chk($sformatf("v%0d_pmem_read", k),  {127'd0, pmem_read},  {127'd0, vecs[k].er});
            chk($sformatf("v%0d_pmem_write", k), {127'd0, pmem_write}, {127'd0, vecs[k].ew});
            chk($sformatf("v%0d_i_resp", k),     {127'd0, i_resp},     {127'd0, vecs[k].eir});
            chk($sformatf("v%0d_d_resp", k),     {127'd0, d_resp},     {127'd0, vecs[k].edr});
            if (vecs[k].src == 2'd1) begin
                chk($sformatf("v%0d_addr", k),  {112'd0, pmem_address}, {112'd0, vecs[k].ia});
                chk($sformatf("v%0d_wdata", k), pmem_wdata, IW);
            end else if (vecs[k].src == 2'd2) begin
                chk($sformatf("v%0d_addr", k),  {112'd0, pmem_address}, {112'd0, vecs[k].da});
                chk($sformatf("v%0d_wdata", k), pmem_wdata, DW);
            end
            if (vecs[k].eir) chk($sformatf("v%0d_i_rdata", k), i_rdata, RD);
            if (vecs[k].edr) chk($sformatf("v%0d_d_rdata", k), d_rdata, RD);
        end

        // Round robin under continuous contention: I, D, I, D, I, D.
        edge_in(); reset = 1'b1; settle();
        edge_in(); reset = 1'b0;
        i_read = 1'b1; i_address = 16'h1111; d_read = 1'b1; d_write = 1'b0; d_address = 16'h2222;
        settle();
        for (int n = 0; n < 6; n++) begin
            int w;
            w = 0;
            do begin
                edge_in(); settle(); w++;
            end while (!pmem_read && w < 6);
            chk($sformatf("rr%0d_grant", n), {127'd0, pmem_read}, {127'd0, 1'b1});
            chk($sformatf("rr%0d_latency", n), 128'(w), 128'd1);
            chk($sformatf("rr%0d_addr", n), {112'd0, pmem_address},
                (n % 2 == 0) ? 128'h1111 : 128'h2222);
            edge_in(); pmem_resp = 1'b1; settle();
            chk($sformatf("rr%0d_i_resp", n), {127'd0, i_resp}, (n % 2 == 0) ? 128'd1 : 128'd0);
            chk($sformatf("rr%0d_d_resp", n), {127'd0, d_resp}, (n % 2 == 0) ? 128'd0 : 128'd1);
            edge_in(); pmem_resp = 1'b0; settle();
            chk($sformatf("rr%0d_idle", n), {126'd0, pmem_read, pmem_write}, 128'd0);
        end

        // D-cache write holds the grant for 5 cycles while the I-cache waits.
        edge_in(); reset = 1'b1; i_read = 1'b0; d_read = 1'b0; settle();
        edge_in(); reset = 1'b0; d_write = 1'b1; d_address = 16'h3333; settle();
        for (int k = 1; k <= 5; k++) begin
            edge_in();
            if (k == 2) begin i_read = 1'b1; i_address = 16'h4444; end
            if (k == 5) pmem_resp = 1'b1;
            settle();
            chk($sformatf("lat%0d_write", k), {127'd0, pmem_write}, 128'd1);
            chk($sformatf("lat%0d_addr", k), {112'd0, pmem_address}, 128'h3333);
            chk($sformatf("lat%0d_i_resp", k), {127'd0, i_resp}, 128'd0);
            chk($sformatf("lat%0d_d_resp", k), {127'd0, d_resp}, (k == 5) ? 128'd1 : 128'd0);
        end
        edge_in(); d_write = 1'b0; pmem_resp = 1'b0; settle();
        chk("lat_idle_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
        edge_in(); settle();
        chk("lat_i_grant", {127'd0, pmem_read}, 128'd1);
        chk("lat_i_addr", {112'd0, pmem_address}, 128'h4444);
        edge_in(); pmem_resp = 1'b1; settle();
        chk("lat_i_resp", {127'd0, i_resp}, 128'd1);
        edge_in(); pmem_resp = 1'b0; i_read = 1'b0; settle();

        // Reset in the third cycle of a D grant aborts it; the I-cache then wins the tie.
        edge_in(); d_read = 1'b1; d_address = 16'h5555; settle();
        for (int k = 1; k <= 3; k++) begin
            edge_in();
            if (k == 3) reset = 1'b1;
            settle();
            chk($sformatf("rst%0d_read", k), {127'd0, pmem_read}, 128'd1);
            chk($sformatf("rst%0d_addr", k), {112'd0, pmem_address}, 128'h5555);
        end
        edge_in(); reset = 1'b0; i_read = 1'b1; i_address = 16'h6666; settle();
        chk("rst_abort_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
        chk("rst_abort_d_resp", {127'd0, d_resp}, 128'd0);
        edge_in(); settle();
        chk("rst_i_first_read", {127'd0, pmem_read}, 128'd1);
        chk("rst_i_first_addr", {112'd0, pmem_address}, 128'h6666);
        edge_in(); pmem_resp = 1'b1; settle();
        chk("rst_i_resp", {127'd0, i_resp}, 128'd1);
        chk("rst_no_d_resp", {127'd0, d_resp}, 128'd0);
        edge_in(); pmem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
